calc3_port_issuer: RTL and testbench
====================================

CALC3_PORT_ISSUER -- requirements
Module: calc3_port_issuer

Interface
REQ-001 Parameter: IN_DEPTH, 4, host request FIFO depth; power of two, 2..16.
REQ-002 c_clk  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  host request present.
REQ-005 in_ready  out  1  FIFO can accept; transfer on in_valid & in_ready at edge.
REQ-006 in_cmd/in_d1/in_d2/in_r1  in  4 each  command, operand regs, result reg.
REQ-007 in_data  in  32  request data.
REQ-008 req_cmd/req_d1/req_d2/req_r1  out  4 each  to calc3 port reqN_*.
REQ-009 req_tag  out  2  to reqN_tag; req_data  out  32  to reqN_data.
REQ-010 out_resp  in  2  from outN_resp; 0 = no response.
REQ-011 out_tag  in  2; out_data  in  32  from outN_tag/outN_data.
REQ-012 rsp_valid  out  1; rsp_resp  out  2; rsp_tag  out  2; rsp_data  out  32  to host.
REQ-013 outstanding  out  3  count of in-flight tags, 0..4.
REQ-014 err_unexpected  out  1  sticky; err_timeout  out  1  sticky.

Function
REQ-015 FIFO: IN_DEPTH entries of {cmd,d1,d2,r1,data}; in_ready = !full; in_cmd = 0 entries are dropped, never enqueued.
REQ-016 Tag pool: 4 tags (0..3), registered free vector; allocation picks lowest-numbered free tag.
REQ-017 FSM IDLE: FIFO empty; req_cmd = 0.
REQ-018 FSM ISSUE: FIFO non-empty and free tag exists; head popped, req_* registered, tag marked busy.
REQ-019 FSM STALL: FIFO non-empty, no free tag; req_cmd = 0; to ISSUE the edge after any tag frees.
REQ-020 Request held on req_* exactly one cycle, then req_cmd = 0 and req_d1/d2/r1/tag/data = 0; back-to-back issues allowed.
REQ-021 Latency: request accepted at edge E appears on req_* after edge E+1 at earliest.
REQ-022 Response: out_resp != 0 with busy out_tag at edge R frees the tag; rsp_valid = 1 with out_resp/out_tag/out_data for one cycle after edge R.
REQ-023 out_resp != 0 with non-busy out_tag: err_unexpected set; no rsp_valid; pool unchanged.
REQ-024 Same-edge free and allocate: freed tag is not reallocated until the following edge.
REQ-025 Simultaneous accept into full-minus-one FIFO and pop: both occur; in_ready stays 1.
REQ-026 outstanding = popcount of busy vector; updated same edge as issue/free; net 0 when both occur.
REQ-027 Unused rsp_* fields = 0 when rsp_valid = 0.

Reset
REQ-028 While reset high: all outputs 0 (incl. in_ready, rsp_valid, err_*), FIFO empty, all tags free, FSM IDLE.
REQ-029 Mid-operation reset discards queued and in-flight requests; responses after reset for old tags raise err_unexpected.
REQ-030 in_ready = 1 on first edge after reset deasserts.

Configuration
REQ-031 Macro CALC3_ISSUER_TIMEOUT_EN defined: per-tag 8-bit age counter starts at issue; at 255 cycles without response tag freed, err_timeout set, no rsp_valid.
REQ-032 Macro undefined: no age counters; err_timeout tied 0; tags free only on response.

Verification
REQ-033 Reset, push cmd=1,d1=2,d2=3,r1=4 -> req_cmd=1,req_tag=0 one cycle; out_resp=1,tag=0 -> rsp_valid,rsp_resp=1,outstanding 1->0.
REQ-034 Push 6 cmd=1 requests, no responses -> tags 0,1,2,3 issued, FSM STALL, outstanding=4; out_resp=1,tag=2 -> 5th issues with tag 2.
REQ-035 Push IN_DEPTH+1 while stalled -> in_ready=0 after IN_DEPTH entries; extra not accepted.
REQ-036 out_resp=2,tag=3 with tag 3 free -> err_unexpected=1, rsp_valid stays 0.
REQ-037 Assert reset with 3 outstanding -> outstanding=0, req_cmd=0; then out_resp=1,tag=0 -> err_unexpected=1.
REQ-038 With CALC3_ISSUER_TIMEOUT_EN, issue tag 0, withhold response 255 cycles -> err_timeout=1, outstanding=0.

Source files
------------

// File: rtl/calc3_port_issuer.sv
// Host-side issuer for one calc3 port: queues requests, tags them from a 4-entry pool, routes responses.
// Optional build macro CALC3_ISSUER_TIMEOUT_EN enables per-tag age counters that reclaim lost tags.
module calc3_port_issuer #(
    parameter int unsigned IN_DEPTH = 4
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cmd,
    input  logic [3:0]  in_d1,
    input  logic [3:0]  in_d2,
    input  logic [3:0]  in_r1,
    input  logic [31:0] in_data,
    output logic [3:0]  req_cmd,
    output logic [3:0]  req_d1,
    output logic [3:0]  req_d2,
    output logic [3:0]  req_r1,
    output logic [1:0]  req_tag,
    output logic [31:0] req_data,
    input  logic [1:0]  out_resp,
    input  logic [1:0]  out_tag,
    input  logic [31:0] out_data,
    output logic        rsp_valid,
    output logic [1:0]  rsp_resp,
    output logic [1:0]  rsp_tag,
    output logic [31:0] rsp_data,
    output logic [2:0]  outstanding,
    output logic        err_unexpected,
    output logic        err_timeout
);

    localparam int unsigned AW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [AW:0] FullCnt = (AW + 1)'(IN_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic [47:0]   mem_q [IN_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    free_q, free_d;
    logic [47:0]   req_q, req_d;
    logic [1:0]    req_tag_q, req_tag_d;
    logic          rsp_valid_q;
    logic [1:0]    rsp_resp_q, rsp_tag_q;
    logic [31:0]   rsp_data_q;
    logic          err_unexp_q, err_unexp_d;

    logic        full, empty, push, issue, alloc_found;
    logic [1:0]  alloc_tag;
    logic        resp_act, resp_hit, resp_bad;
    logic [3:0]  to_fire;
    logic [47:0] head;

    assign full     = (cnt_q == FullCnt);
    assign empty    = (cnt_q == '0);
    assign in_ready = ~full & ~reset;
    // Zero-command requests are consumed from the host but never queued.
    assign push     = in_valid & in_ready & (in_cmd != 4'd0);
    assign head     = mem_q[rd_ptr_q];

    // Lowest-numbered free tag wins; the loop runs high to low so the last hit is the lowest.
    always_comb begin
        alloc_found = 1'b0;
        alloc_tag   = 2'd0;
        for (int t = 3; t >= 0; t--) begin
            if (free_q[t]) begin
                alloc_found = 1'b1;
                alloc_tag   = 2'(t);
            end
        end
    end

    assign issue    = ~empty & alloc_found;
    assign resp_act = (out_resp != 2'd0);
    assign resp_hit = resp_act & ~free_q[out_tag];
    assign resp_bad = resp_act & free_q[out_tag];

`ifdef CALC3_ISSUER_TIMEOUT_EN
    logic [7:0] age_q [4];
    logic [7:0] age_d [4];
    logic       err_to_q;

    always_comb begin
        to_fire = '0;
        for (int t = 0; t < 4; t++) begin
            age_d[t] = age_q[t];
            if (issue && (alloc_tag == 2'(t))) begin
                age_d[t] = 8'd0;
            end else if (!free_q[t]) begin
                if (resp_hit && (out_tag == 2'(t))) begin
                    age_d[t] = 8'd0;
                end else if (age_q[t] == 8'd254) begin
                    to_fire[t] = 1'b1;
                    age_d[t]   = 8'd0;
                end else begin
                    age_d[t] = age_q[t] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < 4; t++) age_q[t] <= 8'd0;
            err_to_q <= 1'b0;
        end else begin
            for (int t = 0; t < 4; t++) age_q[t] <= age_d[t];
            err_to_q <= err_to_q | (|to_fire);
        end
    end

    assign err_timeout = err_to_q;
`else
    assign to_fire     = 4'd0;
    assign err_timeout = 1'b0;
`endif

    // Allocation reads free_q, so a tag released this edge is only reusable next edge.
    always_comb begin
        free_d = free_q | to_fire;
        if (issue) free_d[alloc_tag] = 1'b0;
        if (resp_hit) free_d[out_tag] = 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !issue) cnt_d = cnt_q + 1'b1;
        else if (!push && issue) cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        if (issue) state_d = ST_ISSUE;
        else if (!empty) state_d = ST_STALL;
        else state_d = ST_IDLE;
    end

    assign req_d       = issue ? head : 48'd0;
    assign req_tag_d   = issue ? alloc_tag : 2'd0;
    assign err_unexp_d = err_unexp_q | resp_bad;

    always_ff @(posedge c_clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_cmd, in_d1, in_d2, in_r1, in_data};
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            free_q      <= 4'hf;
            req_q       <= 48'd0;
            req_tag_q   <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_resp_q  <= 2'd0;
            rsp_tag_q   <= 2'd0;
            rsp_data_q  <= 32'd0;
            err_unexp_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            free_q      <= free_d;
            req_q       <= req_d;
            req_tag_q   <= req_tag_d;
            rsp_valid_q <= resp_hit;
            rsp_resp_q  <= resp_hit ? out_resp : 2'd0;
            rsp_tag_q   <= resp_hit ? out_tag : 2'd0;
            rsp_data_q  <= resp_hit ? out_data : 32'd0;
            err_unexp_q <= err_unexp_d;
        end
    end

    always_comb begin
        if (state_q == ST_ISSUE) begin
            {req_cmd, req_d1, req_d2, req_r1, req_data} = req_q;
            req_tag = req_tag_q;
        end else begin
            {req_cmd, req_d1, req_d2, req_r1, req_data} = 48'd0;
            req_tag = 2'd0;
        end
    end

    always_comb begin
        outstanding = 3'd0;
        for (int t = 0; t < 4; t++) outstanding = outstanding + {2'b00, ~free_q[t]};
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_tag        = rsp_tag_q;
    assign rsp_data       = rsp_data_q;
    assign err_unexpected = err_unexp_q;

endmodule

// File: tb/tb_calc3_port_issuer.sv
// Directed self-checking bench for calc3_port_issuer; timeout steps run only with CALC3_ISSUER_TIMEOUT_EN.
module tb_calc3_port_issuer;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd, in_d1, in_d2, in_r1;
    logic [31:0] in_data;
    logic [3:0]  req_cmd, req_d1, req_d2, req_r1;
    logic [1:0]  req_tag;
    logic [31:0] req_data;
    logic [1:0]  out_resp, out_tag;
    logic [31:0] out_data;
    logic        rsp_valid;
    logic [1:0]  rsp_resp, rsp_tag;
    logic [31:0] rsp_data;
    logic [2:0]  outstanding;
    logic        err_unexpected, err_timeout;

    int checks = 0;
    int errors = 0;

    calc3_port_issuer #(.IN_DEPTH(4)) dut (
        .c_clk          (c_clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_cmd         (in_cmd),
        .in_d1          (in_d1),
        .in_d2          (in_d2),
        .in_r1          (in_r1),
        .in_data        (in_data),
        .req_cmd        (req_cmd),
        .req_d1         (req_d1),
        .req_d2         (req_d2),
        .req_r1         (req_r1),
        .req_tag        (req_tag),
        .req_data       (req_data),
        .out_resp       (out_resp),
        .out_tag        (out_tag),
        .out_data       (out_data),
        .rsp_valid      (rsp_valid),
        .rsp_resp       (rsp_resp),
        .rsp_tag        (rsp_tag),
        .rsp_data       (rsp_data),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected),
        .err_timeout    (err_timeout)
    );

    always #5 c_clk = ~c_clk;

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_cmd   = 4'd0;
        in_d1    = 4'd0;
        in_d2    = 4'd0;
        in_r1    = 4'd0;
        in_data  = 32'd0;
        out_resp = 2'd0;
        out_tag  = 2'd0;
        out_data = 32'd0;

        repeat (2) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_req_cmd", 32'(req_cmd), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'({err_unexpected, err_timeout}), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single request/response round trip.
        in_valid = 1'b1; in_cmd = 4'd1; in_d1 = 4'd2; in_d2 = 4'd3; in_r1 = 4'd4;
        in_data  = 32'h0000_1234;
        tick();
        in_valid = 1'b0;
        chk("lat_req_cmd_early", 32'(req_cmd), 32'd0);
        tick();
        chk("t1_req_cmd", 32'(req_cmd), 32'd1);
        chk("t1_req_tag", 32'(req_tag), 32'd0);
        chk("t1_req_regs", 32'({req_d1, req_d2, req_r1}), 32'h234);
        chk("t1_req_data", req_data, 32'h0000_1234);
        chk("t1_outstanding", 32'(outstanding), 32'd1);
        tick();
        chk("t1_req_cmd_drop", 32'(req_cmd), 32'd0);
        chk("t1_req_d1_zero", 32'(req_d1), 32'd0);
        out_resp = 2'd1; out_tag = 2'd0; out_data = 32'h0000_00ab;
        tick();
        out_resp = 2'd0; out_data = 32'd0;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_resp", 32'(rsp_resp), 32'd1);
        chk("t1_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("t1_rsp_data", rsp_data, 32'h0000_00ab);
        chk("t1_outstanding_free", 32'(outstanding), 32'd0);
        tick();
        chk("t1_rsp_valid_off", 32'(rsp_valid), 32'd0);
        chk("t1_rsp_data_zero", rsp_data, 32'd0);

        // Zero-command request is dropped.
        in_valid = 1'b1; in_cmd = 4'd0; in_data = 32'd99;
        tick();
        in_valid = 1'b0;
        tick();
        chk("drop_req_cmd", 32'(req_cmd), 32'd0);
        chk("drop_outstanding", 32'(outstanding), 32'd0);

        // Six back-to-back pushes exhaust the tag pool.
        in_cmd = 4'd1; in_d1 = 4'd0; in_d2 = 4'd0; in_r1 = 4'd0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(16 + i);
            tick();
            if (i >= 1 && i <= 4) begin
                chk("b2b_req_cmd", 32'(req_cmd), 32'd1);
                chk("b2b_req_tag", 32'(req_tag), 32'(i - 1));
                chk("b2b_req_data", req_data, 32'(16 + i - 1));
            end else if (i == 5) begin
                chk("stall_req_cmd", 32'(req_cmd), 32'd0);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("stall_outstanding", 32'(outstanding), 32'd4);
        chk("stall_req_cmd2", 32'(req_cmd), 32'd0);

        // Fill the FIFO while stalled (2 entries already queued).
        in_valid = 1'b1; in_data = 32'h100;
        chk("fill_ready0", 32'(in_ready), 32'd1);
        tick();
        in_data = 32'h101;
        chk("fill_ready1", 32'(in_ready), 32'd1);
        tick();
        in_data = 32'h102;
        chk("fill_full", 32'(in_ready), 32'd0);
        tick();
        chk("fill_full_hold", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Free tag 2: not reused on the freeing edge, reused on the next.
        out_resp = 2'd1; out_tag = 2'd2; out_data = 32'h55;
        tick();
        out_resp = 2'd0; out_data = 32'd0;
        chk("free2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("free2_rsp_tag", 32'(rsp_tag), 32'd2);
        chk("free2_rsp_data", rsp_data, 32'h55);
        chk("free2_outstanding", 32'(outstanding), 32'd3);
        chk("free2_no_same_edge", 32'(req_cmd), 32'd0);
        tick();
        chk("reissue_req_cmd", 32'(req_cmd), 32'd1);
        chk("reissue_req_tag", 32'(req_tag), 32'd2);
        chk("reissue_req_data", req_data, 32'd20);
        chk("reissue_outstanding", 32'(outstanding), 32'd4);
        chk("reissue_rsp_off", 32'(rsp_valid), 32'd0);
        chk("reissue_in_ready", 32'(in_ready), 32'd1);

        // Mid-operation reset with 3 in flight.
        out_resp = 2'd1; out_tag = 2'd1;
        tick();
        out_resp = 2'd0;
        chk("pre_rst_outstanding", 32'(outstanding), 32'd3);
        reset = 1'b1;
        #1;
        chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
        chk("mid_rst_req_cmd", 32'(req_cmd), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        out_resp = 2'd1; out_tag = 2'd0;
        tick();
        out_resp = 2'd0;
        chk("stale_err_unexp", 32'(err_unexpected), 32'd1);
        chk("stale_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stale_outstanding", 32'(outstanding), 32'd0);

        // Unexpected response on a free tag from a clean state.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("clean_err_unexp", 32'(err_unexpected), 32'd0);
        out_resp = 2'd2; out_tag = 2'd3;
        tick();
        out_resp = 2'd0;
        chk("unexp_err", 32'(err_unexpected), 32'd1);
        chk("unexp_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("unexp_outstanding", 32'(outstanding), 32'd0);

`ifdef CALC3_ISSUER_TIMEOUT_EN
        in_valid = 1'b1; in_cmd = 4'd1; in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        tick();
        chk("to_issued", 32'(outstanding), 32'd1);
        repeat (254) tick();
        chk("to_not_yet", 32'(err_timeout), 32'd0);
        chk("to_still_busy", 32'(outstanding), 32'd1);
        tick();
        chk("to_err", 32'(err_timeout), 32'd1);
        chk("to_freed", 32'(outstanding), 32'd0);
        chk("to_no_rsp", 32'(rsp_valid), 32'd0);
`else
        chk("to_tied_off", 32'(err_timeout), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
